// File: rtl/l0_skew_feeder.sv
// Row-parallel vector buffer that launches stored column vectors into the west edge of the MAC array.
// Define L0_SKEW_EN for the diagonal wavefront (row i delayed i cycles); otherwise all rows launch together.
module l0_skew_feeder #(
  parameter int row   = 8,
  parameter int bw    = 4,
  parameter int depth = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [row*bw-1:0] in,
  input  logic              rd,
  input  logic [1:0]        inst_in,
  output logic [row*bw-1:0] out,
  output logic [row*2-1:0]  inst_out,
  output logic [row-1:0]    out_valid,
  output logic              full,
  output logic              ready,
  output logic              empty
);
  localparam int AW = $clog2(depth);
  localparam int PW = AW + 1;
  typedef logic [PW-1:0] ptr_t;

  logic [bw-1:0]     mem_q [row][depth];
  ptr_t              wptr_q, wptr_d;
  ptr_t              rptr_q [row];
  ptr_t              rptr_d [row];
  logic [row*bw-1:0] out_q, out_d;
  logic [row*2-1:0]  inst_q, inst_d;
  logic [row-1:0]    vld_q, vld_d;
  logic [row-1:0]    pop;
  logic [1:0]        pop_tag [row];
  ptr_t              free_ptr;
  logic              wr_acc, rd_acc;

  // Flags come from registered pointers only, so a same-cycle pop never rescues a write.
  assign empty  = (rptr_q[0] == wptr_q);
  assign full   = ((wptr_q - free_ptr) == PW'(depth));
  assign ready  = ~full;
  assign wr_acc = wr & ~full;
  assign rd_acc = rd & ~empty;

`ifdef L0_SKEW_EN
  logic [row-1:1] chain_v_q, chain_v_d;
  logic [1:0]     chain_tag_q [1:row-1];
  logic [1:0]     chain_tag_d [1:row-1];

  // The last row frees entries last, so it alone decides when space returns.
  assign free_ptr = rptr_q[row-1];

  always_comb begin
    chain_v_d      = '0;
    chain_tag_d    = '{default: 2'b00};
    pop            = '0;
    pop_tag        = '{default: 2'b00};
    chain_v_d[1]   = rd_acc;
    chain_tag_d[1] = inst_in;
    for (int i = 2; i < row; i++) begin
      chain_v_d[i]   = chain_v_q[i-1];
      chain_tag_d[i] = chain_tag_q[i-1];
    end
    pop[0]     = rd_acc;
    pop_tag[0] = inst_in;
    for (int i = 1; i < row; i++) begin
      pop[i]     = chain_v_q[i];
      pop_tag[i] = chain_tag_q[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain_v_q   <= '0;
      chain_tag_q <= '{default: 2'b00};
    end else begin
      chain_v_q   <= chain_v_d;
      chain_tag_q <= chain_tag_d;
    end
  end
`else
  assign free_ptr = rptr_q[0];

  always_comb begin
    pop     = {row{rd_acc}};
    pop_tag = '{default: inst_in};
  end
`endif

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    wptr_d = wptr_q + PW'(wr_acc);
    out_d  = out_q;
    inst_d = '0;
    vld_d  = '0;
    rptr_d = rptr_q;
    for (int i = 0; i < row; i++) begin
      if (pop[i]) begin
        out_d[i*bw +: bw] = mem_q[i][rptr_q[i][AW-1:0]];
        inst_d[i*2 +: 2]  = pop_tag[i];
        vld_d[i]          = 1'b1;
        rptr_d[i]         = rptr_q[i] + PW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '{default: '0};
      out_q  <= '0;
      inst_q <= '0;
      vld_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      out_q  <= out_d;
      inst_q <= inst_d;
      vld_q  <= vld_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int i = 0; i < row; i++) begin
        mem_q[i][wptr_q[AW-1:0]] <= in[i*bw +: bw];
      end
    end
  end

  assign out       = out_q;
  assign inst_out  = inst_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_l0_skew_feeder.sv
// Directed bench for l0_skew_feeder: a vector FIFO model plus per-row launch scoreboards predict every output each cycle.
module tb_l0_skew_feeder;
  localparam int ROW   = 8;
  localparam int BW    = 4;
  localparam int DEPTH = 64;
  localparam int VW    = ROW * BW;
`ifdef L0_SKEW_EN
  localparam int SKEW = 1;
`else
  localparam int SKEW = 0;
`endif

  typedef struct {
    int            cyc;
    logic [BW-1:0] d;
    logic [1:0]    t;
  } ev_t;

  logic            clk = 1'b0;
  logic            reset_s = 1'b1;
  logic            wr_s = 1'b0;
  logic [VW-1:0]   in_s = '0;
  logic            rd_s = 1'b0;
  logic [1:0]      inst_s = 2'b00;
  logic [VW-1:0]   out_w;
  logic [ROW*2-1:0] inst_w;
  logic [ROW-1:0]  vld_w;
  logic            full_w, ready_w, empty_w;

  l0_skew_feeder #(.row(ROW), .bw(BW), .depth(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset_s),
    .wr       (wr_s),
    .in       (in_s),
    .rd       (rd_s),
    .inst_in  (inst_s),
    .out      (out_w),
    .inst_out (inst_w),
    .out_valid(vld_w),
    .full     (full_w),
    .ready    (ready_w),
    .empty    (empty_w)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [VW-1:0]    fifo [$];
  ev_t              rowq [ROW][$];
  int               occ;
  int               ecnt;
  logic [VW-1:0]    exp_out;
  logic [ROW*2-1:0] exp_inst;
  logic [ROW-1:0]   exp_v;
  int               n_checks = 0;
  int               n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string phase);
    chk({phase, ".out"}, 64'(out_w), 64'(exp_out));
    chk({phase, ".inst_out"}, 64'(inst_w), 64'(exp_inst));
    chk({phase, ".out_valid"}, 64'(vld_w), 64'(exp_v));
    chk({phase, ".full"}, 64'(full_w), 64'(occ == DEPTH));
    chk({phase, ".ready"}, 64'(ready_w), 64'(occ != DEPTH));
    chk({phase, ".empty"}, 64'(empty_w), 64'(fifo.size() == 0));
  endtask

  task automatic model_clear();
    fifo.delete();
    for (int i = 0; i < ROW; i++) rowq[i].delete();
    occ      = 0;
    exp_out  = '0;
    exp_inst = '0;
    exp_v    = '0;
  endtask

  // One clock edge: update the model from pre-edge state, then compare outputs 1 time unit later.
  task automatic tick(input string phase);
    bit            full_pre;
    bit            empty_pre;
    logic [VW-1:0] vec;
    ev_t           ev;
    full_pre  = (occ == DEPTH);
    empty_pre = (fifo.size() == 0);
    @(posedge clk);
    if (rd_s && !empty_pre) begin
      vec = fifo.pop_front();
      for (int i = 0; i < ROW; i++) begin
        ev.cyc = ecnt + i * SKEW;
        ev.d   = vec[i*BW +: BW];
        ev.t   = inst_s;
        rowq[i].push_back(ev);
      end
    end
    if (wr_s && !full_pre) begin
      fifo.push_back(in_s);
      occ++;
    end
    exp_inst = '0;
    exp_v    = '0;
    for (int i = 0; i < ROW; i++) begin
      if (rowq[i].size() > 0 && rowq[i][0].cyc == ecnt) begin
        ev = rowq[i].pop_front();
        exp_out[i*BW +: BW] = ev.d;
        exp_inst[i*2 +: 2]  = ev.t;
        exp_v[i]            = 1'b1;
        if (i == ROW - 1) occ--;
      end
    end
    ecnt++;
    #1;
    check_all(phase);
  endtask

  task automatic cyc(input string phase, input bit w, input logic [VW-1:0] d,
                     input bit r, input logic [1:0] t);
    wr_s   = w;
    in_s   = d;
    rd_s   = r;
    inst_s = t;
    tick(phase);
  endtask

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < ROW; i++) v[i*BW +: BW] = BW'($urandom);
    return v;
  endfunction

  initial begin
    logic [VW-1:0] ramp;
    ecnt = 0;
    model_clear();

    // Reset state
    reset_s = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset_s = 1'b0;

    // Single vector 1..8 launched with kernel-load instruction
    ramp = '0;
    for (int i = 0; i < ROW; i++) ramp[i*BW +: BW] = BW'(i + 1);
    cyc("ramp_wr", 1'b1, ramp, 1'b0, 2'b00);
    cyc("ramp_rd", 1'b0, '0, 1'b1, 2'b01);
    repeat (ROW + 1) cyc("ramp_wave", 1'b0, '0, 1'b0, 2'b00);

    // Fill to full, drop the extra write, then free one slot and refill
    repeat (DEPTH + 1) cyc("fill", 1'b1, rnd_vec(), 1'b0, 2'b00);
    cyc("full_rd", 1'b0, '0, 1'b1, 2'b11);
    repeat (ROW + 2) cyc("refill", 1'b1, rnd_vec(), 1'b0, 2'b00);
    repeat (DEPTH + 4) cyc("drain", 1'b0, '0, 1'b1, 2'($urandom));
    repeat (ROW) cyc("drain_idle", 1'b0, '0, 1'b0, 2'b00);

    // Reads on empty are dropped; a simultaneous write is still accepted
    cyc("rd_empty", 1'b0, '0, 1'b1, 2'b10);
    cyc("wr_rd_empty", 1'b1, rnd_vec(), 1'b1, 2'b10);
    cyc("after_wr_rd", 1'b0, '0, 1'b0, 2'b00);
    cyc("rd_one", 1'b0, '0, 1'b1, 2'b01);
    repeat (ROW) cyc("rd_one_wave", 1'b0, '0, 1'b0, 2'b00);

    // Eight back-to-back launches with the execute instruction
    repeat (8) cyc("b2b_wr", 1'b1, rnd_vec(), 1'b0, 2'b00);
    repeat (8) cyc("b2b_rd", 1'b0, '0, 1'b1, 2'b10);
    repeat (ROW + 1) cyc("b2b_wave", 1'b0, '0, 1'b0, 2'b00);

    // Concurrent write/read pairs across pointer wrap
    repeat (130) cyc("wrap", 1'b1, rnd_vec(), 1'b1, 2'($urandom));
    repeat (2) cyc("wrap_tail", 1'b0, '0, 1'b1, 2'b01);
    repeat (ROW) cyc("wrap_idle", 1'b0, '0, 1'b0, 2'b00);

    // Asynchronous reset while the wavefront is mid-array
    cyc("mid_wr", 1'b1, rnd_vec(), 1'b0, 2'b00);
    cyc("mid_rd", 1'b0, '0, 1'b1, 2'b10);
    repeat (3) cyc("mid_wave", 1'b0, '0, 1'b0, 2'b00);
    reset_s = 1'b1;
    #1;
    model_clear();
    check_all("async_reset");
    @(posedge clk);
    #1;
    check_all("reset_hold");
    reset_s = 1'b0;
    repeat (ROW + 2) cyc("post_reset", 1'b0, '0, 1'b0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/l0_skew_feeder.md
# l0_skew_feeder

Row-parallel input buffer and diagonal skew generator that sits directly west of the MAC array and drives each array row's `in_w`/`inst_w` pair. It stores full column vectors of activations or weights (one `bw`-bit element per row) written by the core controller. On each read request it launches that vector into the array with row `i` delayed `i` cycles, which gives the systolic wavefront the tiles expect. The instruction bits travel with the data, so every tile sees data and instruction in the same cycle, and sees `inst_w = 2'b00` when idle.

## Interface
Parameters:
- `row`, 8, number of array rows fed (≥2)
- `bw`, 4, element width; matches the tile `bw`
- `depth`, 64, vector entries per row; power of two

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `wr`  in  1  write request; pushes `in` as one vector
- `in`  in  `row*bw`  write vector; row `i` at bits `[i*bw +: bw]`
- `rd`  in  1  read/launch request
- `inst_in`  in  2  instruction launched with the vector: [1] execute, [0] kernel load
- `out`  out  `row*bw`  per-row data to tile `in_w`; row `i` at `[i*bw +: bw]`
- `inst_out`  out  `row*2`  per-row instruction to tile `inst_w`; row `i` at `[i*2 +: 2]`
- `out_valid`  out  `row`  row `i` output carries a launched element this cycle
- `full`  out  1  no free entry; `wr` is ignored
- `ready`  out  1  equals `~full`
- `empty`  out  1  no unlaunched vector for row 0; `rd` is ignored

## Operation
- Storage is `row` independent arrays of `depth` x `bw`. A write stores all rows at a shared write pointer `wptr`.
- Pointers are `log2(depth)+1` bits wide and wrap modulo `2*depth`. Each row `i` has its own read pointer `rptr[i]`.
- `empty = (rptr[0] == wptr)`.
- `full = (wptr - rptr[row-1] == depth)`. The last row frees entries last.
- Flags are derived from registered pointers only. A write while `full` is dropped, even if a read occurs in the same cycle. A read while `empty` is dropped, even if a write occurs in the same cycle.
- An accepted read (`rd & ~empty`) at edge k does the following:
  - Enters a skew shift chain tagged with `inst_in`.
  - Row `i` pops at edge k+i: loads `out[i]` from `mem[i][rptr[i]]`, increments `rptr[i]`, sets `out_valid[i]=1` and `inst_out[i]=tag`.
- Later rows can never underflow: row `i` only pops an entry that row 0 already popped.
- A row with no pop at an edge sets `out_valid[i]=0` and `inst_out[i]=2'b00`. `out[i]` holds its last value.
- Back-to-back `rd` produces one vector per cycle per row, with no bubbles.
- Writes, launches and pops proceed concurrently; the pointers are independent.

## Timing
- Reset clears all pointers, the skew chain, `out`, `inst_out` and `out_valid` to 0. It sets `empty=1`, `full=0`, `ready=1`. Memory contents are not reset. An in-flight wavefront is discarded.
- Write-to-read: a vector written at edge k is launchable (`empty=0`) from the cycle after edge k.
- Launch latency: row `i` outputs are visible in the cycle after edge k+i. The full wavefront completes `row` cycles after the launch edge.
- `full` deasserts the cycle after row `row-1` pops.

## Configuration
- `L0_SKEW_EN` defined: diagonal skew as above.
- `L0_SKEW_EN` undefined: no skew chain. All rows pop at edge k, so the whole vector and `inst_out` appear in the same cycle. In this mode `full` uses `rptr[0]`, since all read pointers are equal.

## Test plan
- Reset, write rows 0..7 = 1..8, then pulse `rd` with `inst_in=2'b01`: row `i` shows value `i+1` with `out_valid[i]=1` and `inst_out[i]=01` exactly at cycle k+1+i, and 00 otherwise.
- Write 64 vectors: `full=1`, `ready=0` after the 64th. A 65th write is dropped. A read followed by writes preserves order 0..63 with no loss.
- `rd` on empty: no `out_valid` in any row, and the pointers are unchanged. A simultaneous `wr`+`rd` on empty accepts only the write.
- Eight back-to-back `rd` with `inst_in=2'b10`: every row outputs 8 consecutive valid cycles in FIFO order, with row 7 lagging row 0 by 7 cycles.
- Run 130 write/read pairs (pointer wrap ×2): data matches a scoreboard, and the flags stay correct across wrap.
- Assert `reset` mid-wavefront (row 3 popping): all outputs go to 0 immediately (async), `empty=1`, and no further `out_valid` appears after release.
